// File: rtl/alu_serial_sequencer.sv
// alu_serial_sequencer
//   Drives one serial ALU on behalf of a parallel requester. A command (A, B, op)
//   is accepted over a valid/ready handshake and sent on sin as nine 11-bit packets:
//   start 0, type, 8 payload bits, stop 1, MSB first. The ALU's reply on sout is
//   either five packets (four result bytes and one ctl packet with flags and CRC3)
//   or one error packet. The decoded result is returned on a second valid/ready
//   handshake. Only one transaction is in flight at a time.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   cmd_valid/ready   command handshake; cmd_a, cmd_b, cmd_op, cmd_crc_inv
//   sin               serial line to the ALU (idle high)
//   sout              serial line from the ALU (idle high)
//   rsp_valid/ready   response handshake
//   rsp_c             result C
//   rsp_flags         {carry, overflow, zero, negative}
//   rsp_err           error packet received; rsp_err_flags = {data, crc, op}
//   rsp_chk_ok        reply CRC3 or error-packet parity correct
//   rsp_timeout       no complete reply within TIMEOUT_CYCLES
//   busy              state is not IDLE
//
// state | meaning
// IDLE  | ready for a command
// TX    | shifting the 99-bit command frame out on sin
// WAIT  | sin idle, waiting for the first reply start bit
// RX    | collecting reply packets
// DONE  | response presented, waiting for rsp_ready
// GAP   | holding sin high for IDLE_GAP clocks before the next command

module alu_serial_sequencer #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int IDLE_GAP       = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    input  logic [2:0]  cmd_op,
    input  logic        cmd_crc_inv,
    output logic        sin,
    input  logic        sout,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_c,
    output logic [3:0]  rsp_flags,
    output logic        rsp_err,
    output logic [2:0]  rsp_err_flags,
    output logic        rsp_chk_ok,
    output logic        rsp_timeout,
    output logic        busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(IDLE_GAP + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_TX, S_WAIT, S_RX, S_DONE, S_GAP
    } state_t;

    state_t r_state, w_state_nxt;

    logic          r_rdy;
    logic [98:0]   r_tx_sr;
    logic [6:0]    r_tx_cnt;
    logic [TW-1:0] r_tmo;
    logic [3:0]    r_rx_cnt;
    logic [8:0]    r_rx_sr;
    logic [2:0]    r_pkt;
    logic [31:0]   r_c_acc;
    logic [GW-1:0] r_gap;
    logic [31:0]   r_rsp_c;
    logic [3:0]    r_rsp_flags;
    logic          r_rsp_err;
    logic [2:0]    r_rsp_err_flags;
    logic          r_rsp_chk_ok;
    logic          r_rsp_timeout;

    logic [3:0]    w_crc4;
    logic [98:0]   w_tx_frame;
    logic          w_tmo_last;
    logic          w_type;
    logic [7:0]    w_pay;
    logic          w_err_pkt;
    logic          w_rx_end;
    logic [2:0]    w_crc3;

    // Direct LFSR form (no augmentation), MSB first, initial value 0.
    function automatic logic [3:0] crc4_calc(input logic [67:0] d);
        logic [3:0] c;
        logic       fb;
        c = 4'b0000;
        for (int i = 67; i >= 0; i--) begin
            fb = c[3] ^ d[i];
            c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
        end
        return c;
    endfunction

    function automatic logic [2:0] crc3_calc(input logic [36:0] d);
        logic [2:0] c;
        logic       fb;
        c = 3'b000;
        for (int i = 36; i >= 0; i--) begin
            fb = c[2] ^ d[i];
            c  = {c[1:0], 1'b0} ^ (fb ? 3'b011 : 3'b000);
        end
        return c;
    endfunction

    assign w_crc4 = crc4_calc({cmd_b, cmd_a, 1'b1, cmd_op}) ^ {4{cmd_crc_inv}};

    assign w_tx_frame = {
        2'b00, cmd_b[31:24], 1'b1,
        2'b00, cmd_b[23:16], 1'b1,
        2'b00, cmd_b[15:8],  1'b1,
        2'b00, cmd_b[7:0],   1'b1,
        2'b00, cmd_a[31:24], 1'b1,
        2'b00, cmd_a[23:16], 1'b1,
        2'b00, cmd_a[15:8],  1'b1,
        2'b00, cmd_a[7:0],   1'b1,
        2'b01, 1'b0, cmd_op, w_crc4, 1'b1
    };

    // Down-counter loaded at the end of TX; the clock on which it would reach
    // zero is the TIMEOUT_CYCLES-th clock after the last sin bit.
    assign w_tmo_last = (r_tmo == TW'(1));

    // At r_rx_cnt == 10 the shift register holds {type, payload} and sout is the stop bit.
    assign w_type    = r_rx_sr[8];
    assign w_pay     = r_rx_sr[7:0];
    assign w_err_pkt = (r_pkt == 3'd0) && w_type && w_pay[7];
    assign w_crc3    = crc3_calc({r_c_acc, 1'b0, w_pay[6:3]});
    // A type-1 packet ends reception: either the error packet, the closing ctl
    // packet, or an out-of-sequence ctl packet. A bad stop bit also ends it.
    assign w_rx_end  = (r_rx_cnt == 4'd10) && (!sout || w_type || (r_pkt == 3'd4));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        sin         = 1'b1;
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy      = 1'b0;
                cmd_ready = r_rdy;
                if (r_rdy && cmd_valid) begin
                    w_state_nxt = S_TX;
                end
            end
            S_TX: begin
                sin = r_tx_sr[98];
                if (r_tx_cnt == 7'd98) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!sout) begin
                    w_state_nxt = S_RX;
                end else if (w_tmo_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_RX: begin
                if (w_rx_end || w_tmo_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap == '0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy           <= 1'b0;
            r_tx_sr         <= '1;
            r_tx_cnt        <= '0;
            r_tmo           <= '0;
            r_rx_cnt        <= '0;
            r_rx_sr         <= '0;
            r_pkt           <= '0;
            r_c_acc         <= '0;
            r_gap           <= '0;
            r_rsp_c         <= '0;
            r_rsp_flags     <= '0;
            r_rsp_err       <= 1'b0;
            r_rsp_err_flags <= '0;
            r_rsp_chk_ok    <= 1'b0;
            r_rsp_timeout   <= 1'b0;
        end else begin
            r_rdy <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (r_rdy && cmd_valid) begin
                        r_tx_sr  <= w_tx_frame;
                        r_tx_cnt <= '0;
                    end
                end
                S_TX: begin
                    r_tx_sr  <= {r_tx_sr[97:0], 1'b1};
                    r_tx_cnt <= r_tx_cnt + 7'd1;
                    r_tmo    <= TW'(TIMEOUT_CYCLES);
                    r_rx_cnt <= '0;
                    r_pkt    <= '0;
                    r_c_acc  <= '0;
                end
                S_WAIT: begin
                    r_tmo <= r_tmo - TW'(1);
                    if (!sout) begin
                        r_rx_cnt <= 4'd1;
                    end else if (w_tmo_last) begin
                        r_rsp_timeout <= 1'b1;
                    end
                end
                S_RX: begin
                    r_tmo <= r_tmo - TW'(1);
                    if (r_rx_cnt == 4'd0) begin
                        if (!sout) begin
                            r_rx_cnt <= 4'd1;
                        end
                    end else if (r_rx_cnt == 4'd10) begin
                        r_rx_cnt <= 4'd0;
                        r_pkt    <= r_pkt + 3'd1;
                        if (sout) begin
                            if (w_err_pkt) begin
                                r_rsp_err       <= 1'b1;
                                r_rsp_err_flags <= w_pay[6:4];
                                r_rsp_chk_ok    <= (w_pay[6:4] == w_pay[3:1]) && !(^w_pay);
                            end else if (r_pkt != 3'd4) begin
                                if (!w_type) begin
                                    r_c_acc <= {r_c_acc[23:0], w_pay};
                                end
                            end else if (w_type) begin
                                r_rsp_c      <= r_c_acc;
                                r_rsp_flags  <= w_pay[6:3];
                                r_rsp_chk_ok <= (w_pay[2:0] == w_crc3);
                            end
                        end
                    end else begin
                        r_rx_sr  <= {r_rx_sr[7:0], sout};
                        r_rx_cnt <= r_rx_cnt + 4'd1;
                    end
                    if (!w_rx_end && w_tmo_last) begin
                        r_rsp_timeout <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        r_rsp_c         <= '0;
                        r_rsp_flags     <= '0;
                        r_rsp_err       <= 1'b0;
                        r_rsp_err_flags <= '0;
                        r_rsp_chk_ok    <= 1'b0;
                        r_rsp_timeout   <= 1'b0;
                        r_gap           <= GW'(IDLE_GAP - 1);
                    end
                end
                S_GAP: begin
                    r_gap <= r_gap - GW'(1);
                end
                default: ;
            endcase
        end
    end

    assign rsp_c         = r_rsp_c;
    assign rsp_flags     = r_rsp_flags;
    assign rsp_err       = r_rsp_err;
    assign rsp_err_flags = r_rsp_err_flags;
    assign rsp_chk_ok    = r_rsp_chk_ok;
    assign rsp_timeout   = r_rsp_timeout;

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Directed bench for alu_serial_sequencer: the bench plays the serial ALU,
// captures each 99-bit command frame, and replies with hand-chosen results.
module tb_alu_serial_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic [2:0]  cmd_op;
    logic        cmd_crc_inv;
    logic        sin;
    logic        sout;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_c;
    logic [3:0]  rsp_flags;
    logic        rsp_err;
    logic [2:0]  rsp_err_flags;
    logic        rsp_chk_ok;
    logic        rsp_timeout;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_serial_sequencer #(.TIMEOUT_CYCLES(1024), .IDLE_GAP(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_crc_inv(cmd_crc_inv),
        .sin(sin), .sout(sout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_c(rsp_c), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .rsp_err_flags(rsp_err_flags), .rsp_chk_ok(rsp_chk_ok),
        .rsp_timeout(rsp_timeout), .busy(busy)
    );

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    // CRCs by polynomial long division of the zero-augmented message.
    function automatic logic [3:0] crc4_div(input logic [67:0] m);
        logic [71:0] r;
        r = {m, 4'b0000};
        for (int i = 71; i >= 4; i--)
            if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
        return r[3:0];
    endfunction

    function automatic logic [2:0] crc3_div(input logic [36:0] m);
        logic [39:0] r;
        r = {m, 3'b000};
        for (int i = 39; i >= 3; i--)
            if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
        return r[2:0];
    endfunction

    function automatic logic [98:0] exp_tx(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op, input logic inv);
        logic [3:0] c;
        c = crc4_div({b, a, 1'b1, op}) ^ {4{inv}};
        return {2'b00, b[31:24], 1'b1, 2'b00, b[23:16], 1'b1,
                2'b00, b[15:8], 1'b1, 2'b00, b[7:0], 1'b1,
                2'b00, a[31:24], 1'b1, 2'b00, a[23:16], 1'b1,
                2'b00, a[15:8], 1'b1, 2'b00, a[7:0], 1'b1,
                2'b01, 1'b0, op, c, 1'b1};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [98:0] obs, input logic [98:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge. Returns at the negedge inside the last frame bit.
    task automatic send_cmd(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                            input logic inv, input logic noise,
                            output int waited, output logic [98:0] cap);
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_crc_inv = inv; cmd_valid = 1'b1;
        waited = 0;
        while (!cmd_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        chk("cmd_accept", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 99; i++) begin
            if (i > 0) @(negedge clk);
            if (noise && i == 10) sout = 1'b0;
            if (noise && i == 20) sout = 1'b1;
            cap[98 - i] = sin;
        end
    endtask

    task automatic send_pkt(input logic typ, input logic [7:0] pay, input logic stop);
        logic [10:0] p;
        p = {1'b0, typ, pay, stop};
        for (int i = 10; i >= 0; i--) begin
            @(negedge clk);
            sout = p[i];
        end
    endtask

    task automatic send_data_reply(input logic [31:0] c, input logic [3:0] f,
                                   input logic flip, input int bad_stop);
        logic [2:0] k;
        k = crc3_div({c, 1'b0, f});
        if (flip) k[0] = ~k[0];
        repeat (3) begin @(negedge clk); sout = 1'b1; end
        for (int i = 0; i < 4; i++) begin
            send_pkt(1'b0, c[31 - 8*i -: 8], (bad_stop != i));
            if (i == 1) begin @(negedge clk); sout = 1'b1; end
        end
        send_pkt(1'b1, {1'b0, f, k}, 1'b1);
        @(negedge clk);
        sout = 1'b1;
    endtask

    task automatic send_err_reply(input logic [7:0] pay);
        repeat (3) begin @(negedge clk); sout = 1'b1; end
        send_pkt(1'b1, pay, 1'b1);
        @(negedge clk);
        sout = 1'b1;
    endtask

    task automatic check_rsp(input string tag, input logic [31:0] c, input logic [3:0] f,
                             input logic err, input logic [2:0] ef, input logic ok,
                             input logic to);
        int k;
        k = 0;
        while (!rsp_valid && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk({tag, ".valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, ".c"}, rsp_c, c);
        chk({tag, ".flags"}, 32'(rsp_flags), 32'(f));
        chk({tag, ".err"}, 32'(rsp_err), 32'(err));
        chk({tag, ".err_flags"}, 32'(rsp_err_flags), 32'(ef));
        chk({tag, ".chk_ok"}, 32'(rsp_chk_ok), 32'(ok));
        chk({tag, ".timeout"}, 32'(rsp_timeout), 32'(to));
        chk({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, ".valid_cleared"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".c_cleared"}, rsp_c, 32'd0);
        chk({tag, ".busy_gap"}, 32'(busy), 32'd1);
    endtask

    initial begin
        int w;
        int cnt;
        logic [98:0] cap;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
        cmd_crc_inv = 1'b0; sout = 1'b1; rsp_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset.sin", 32'(sin), 32'd1);
        chk("reset.cmd_ready", 32'(cmd_ready), 32'd0);
        chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.rsp_c", rsp_c, 32'd0);
        chk("reset.rsp_timeout", 32'(rsp_timeout), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("ready_before_first_clk", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        chk("ready_after_first_clk", 32'(cmd_ready), 32'd1);

        // ADD 1+2, with sout noise during TX that must be ignored
        send_cmd(32'd1, 32'd2, 3'b100, 1'b0, 1'b1, w, cap);
        chk_vec("tx.add_1_2", cap, exp_tx(32'd1, 32'd2, 3'b100, 1'b0));
        send_data_reply(32'd3, 4'b0000, 1'b0, -1);
        check_rsp("add_1_2", 32'd3, 4'b0000, 1'b0, 3'b000, 1'b1, 1'b0);

        // AND, issued back to back: ready only after the 2-clock gap
        send_cmd(32'hFFFF0000, 32'h0000FFFF, 3'b000, 1'b0, 1'b0, w, cap);
        chk("gap_wait", 32'(w), 32'd2);
        chk_vec("tx.and", cap, exp_tx(32'hFFFF0000, 32'h0000FFFF, 3'b000, 1'b0));
        send_data_reply(32'd0, 4'b0010, 1'b0, -1);
        check_rsp("and", 32'd0, 4'b0010, 1'b0, 3'b000, 1'b1, 1'b0);

        // SUB 0-1
        send_cmd(32'd0, 32'd1, 3'b101, 1'b0, 1'b0, w, cap);
        chk_vec("tx.sub", cap, exp_tx(32'd0, 32'd1, 3'b101, 1'b0));
        send_data_reply(32'hFFFFFFFF, 4'b1001, 1'b0, -1);
        check_rsp("sub", 32'hFFFFFFFF, 4'b1001, 1'b0, 3'b000, 1'b1, 1'b0);

        // OR with inverted CRC4; ALU answers with crc error packet 1_010_010_1
        send_cmd(32'd5, 32'd3, 3'b001, 1'b1, 1'b0, w, cap);
        chk_vec("tx.or_inv", cap, exp_tx(32'd5, 32'd3, 3'b001, 1'b1));
        send_err_reply(8'hA5);
        check_rsp("or_crcinv", 32'd0, 4'b0000, 1'b1, 3'b010, 1'b1, 1'b0);

        // OR, reply with one CRC3 bit flipped
        send_cmd(32'd5, 32'd3, 3'b001, 1'b0, 1'b0, w, cap);
        send_data_reply(32'd7, 4'b0000, 1'b1, -1);
        check_rsp("crc3_flip", 32'd7, 4'b0000, 1'b0, 3'b000, 1'b0, 1'b0);

        // Error packet with bad parity
        send_cmd(32'd5, 32'd3, 3'b001, 1'b1, 1'b0, w, cap);
        send_err_reply(8'hA4);
        check_rsp("err_bad_parity", 32'd0, 4'b0000, 1'b1, 3'b010, 1'b0, 1'b0);

        // Stop bit 0 in the second reply packet ends RX with a bad check
        send_cmd(32'd1, 32'd2, 3'b100, 1'b0, 1'b0, w, cap);
        send_data_reply(32'd3, 4'b0000, 1'b0, 1);
        check_rsp("bad_stop", 32'd0, 4'b0000, 1'b0, 3'b000, 1'b0, 1'b0);

        // Silent ALU: timeout exactly 1024 clocks after the last sin bit
        send_cmd(32'd9, 32'd4, 3'b100, 1'b0, 1'b0, w, cap);
        @(posedge clk);
        cnt = 0;
        while (cnt < 1100) begin
            @(posedge clk);
            cnt++;
            #1;
            if (rsp_valid) break;
        end
        chk("timeout_latency", 32'(cnt), 32'd1024);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold.valid", 32'(rsp_valid), 32'd1);
            chk("hold.cmd_ready", 32'(cmd_ready), 32'd0);
            chk("hold.timeout", 32'(rsp_timeout), 32'd1);
        end
        check_rsp("timeout", 32'd0, 4'b0000, 1'b0, 3'b000, 1'b0, 1'b1);

        // Reset in the middle of TX (bit 40 is B[2] = 0 for B=8)
        cmd_a = 32'd7; cmd_b = 32'd8; cmd_op = 3'b100; cmd_crc_inv = 1'b0; cmd_valid = 1'b1;
        w = 0;
        while (!cmd_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort.sin_before", 32'(sin), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort.sin", 32'(sin), 32'd1);
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.cmd_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort.ready_again", 32'(cmd_ready), 32'd1);
        send_cmd(32'd7, 32'd8, 3'b100, 1'b0, 1'b0, w, cap);
        chk_vec("tx.add_7_8", cap, exp_tx(32'd7, 32'd8, 3'b100, 1'b0));
        send_data_reply(32'd15, 4'b0000, 1'b0, -1);
        check_rsp("add_7_8", 32'd15, 4'b0000, 1'b0, 3'b000, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_serial_sequencer.md
Name: alu_serial_sequencer

Overview:
- Controller that sequences one serial ALU for a parallel requester.
- Accepts a command (A, B, operation) over a valid/ready handshake.
- Serializes the command into nine 11-bit packets on sin, then collects the ALU's reply on sout: five packets for a result, or one packet for an error.
- Checks the reply CRC and returns the decoded result on a second valid/ready handshake.
- Sits between the testbench or system driver and the ALU serial pins; one transaction in flight at a time.

Parameters:
- TIMEOUT_CYCLES, 1024, clocks allowed after the last sin bit before a missing reply is declared.
- IDLE_GAP, 2, minimum clocks sin is held high between transactions.

Ports:
- clk  in  1  clock; sin and sout advance one bit per clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_a  in  32  operand A.
- cmd_b  in  32  operand B.
- cmd_op  in  3  operation: 000 AND, 001 OR, 100 ADD, 101 SUB; other codes are passed through unchanged.
- cmd_crc_inv  in  1  invert the transmitted CRC4 (error injection).
- sin  out  1  serial line to the ALU, idle high.
- sout  in  1  serial line from the ALU, idle high.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_c  out  32  result C.
- rsp_flags  out  4  {carry, overflow, zero, negative}.
- rsp_err  out  1  ALU returned an error packet.
- rsp_err_flags  out  3  {data, crc, op}.
- rsp_chk_ok  out  1  reply CRC3 (or error-packet parity) is correct.
- rsp_timeout  out  1  no reply within TIMEOUT_CYCLES.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State IDLE; sin=1, cmd_ready=0, rsp_valid=0, busy=0.
  - All rsp_* outputs 0; counters cleared.
  - cmd_ready rises on the first clock after rst_n deasserts.
  - Reset mid-transfer aborts immediately: sin returns high and any partial reply is discarded.
- Packet format, transmitted MSB first: start 0, type (0 data / 1 ctl), 8 payload bits, stop 1.
- TX order:
  - Four data packets carrying B[31:24] down to B[7:0].
  - Four data packets carrying A[31:24] down to A[7:0].
  - One ctl packet with payload {0, op[2:0], crc4[3:0]}.
  - Total 99 bits on 99 consecutive clocks, no gaps.
- CRC4: polynomial x^4+x+1, initial value 0, over the 68 bits {B, A, 1'b1, op}, MSB first. When cmd_crc_inv=1, ~crc4 is sent instead.
- State machine:
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch the command, compute CRC4, go to TX. The first sin bit (0) appears on the next clock.
  - TX: shift one bit per clock. After bit 99, hold sin=1, clear the timeout counter, go to WAIT.
  - WAIT: timeout counter increments each clock. The first sout=0 sample starts RX. Counter reaching TIMEOUT_CYCLES goes to DONE with rsp_timeout=1.
  - RX:
    - Sample 11 bits per packet.
    - A first packet with type=1 and payload[7]=1 is an error packet: payload is {1, err[2:0], err[2:0], parity}. Load err into rsp_err_flags, set rsp_err=1. rsp_chk_ok=1 when the two err copies match and the parity makes {1, err, err, parity} even.
    - Otherwise collect 4 data packets into C (MSB byte first), then a ctl packet with payload {0, flags[3:0], crc3[2:0]}. CRC3 uses polynomial x^3+x+1, initial 0, over the 37 bits {C, 1'b0, flags}. rsp_chk_ok=1 when it matches.
    - A packet with the wrong type bit in sequence, or a stop bit of 0, gives rsp_chk_ok=0 and ends RX at that packet.
    - Between reply packets, sout high is ignored; the timeout counter keeps running. A timeout inside RX also goes to DONE with rsp_timeout=1.
  - DONE: rsp_valid=1; rsp_* stay stable until rsp_valid&&rsp_ready. Then clear rsp_valid and go to GAP.
  - GAP: IDLE_GAP clocks with sin=1, then IDLE.
- sout activity while in IDLE, TX or GAP is ignored.
- rsp_* fields not applicable to the reply type read 0.

Test Plan:
- Reset with ALU model: ADD A=1, B=2 → sin carries 99 bits (B bytes 00 00 00 02, A bytes 00 00 00 01, ctl op 100 plus CRC4). Model reply gives rsp_c=3, rsp_flags=0000, rsp_chk_ok=1, rsp_err=0.
- AND A=FFFF0000, B=0000FFFF → rsp_c=0, rsp_flags=0010; SUB A=0, B=1 → rsp_c=FFFFFFFF, carry=1, negative=1.
- cmd_crc_inv=1 on OR A=5, B=3 → model returns error packet with err=010 → rsp_err=1, rsp_err_flags=010, rsp_chk_ok=1.
- Reply with one flipped CRC3 bit → rsp_chk_ok=0, rsp_c still reported. Error packet with bad parity → rsp_chk_ok=0.
- Model silent, TIMEOUT_CYCLES=1024 → rsp_valid exactly 1024 clocks after the last sin bit, with rsp_timeout=1. Hold rsp_ready=0 for 10 clocks → outputs stable and cmd_ready=0 throughout.
- Assert rst_n at TX bit 40 → sin=1 and busy=0 immediately; a subsequent ADD 7+8 completes with rsp_c=15. Back-to-back commands are separated by at least 2 idle-high clocks on sin.
